// File: rtl/pwr_seq_ctrl.sv
// Board power sequencer: VCORE -> P1V8 -> P3V3 -> P1V1 bring-up, PG timeout and
// rail-loss fault latching, and reverse-order power-down.
//
// state   | meaning
// OFF     | all rails off, waiting for pwr_req
// WAIT_VC | waiting for VCORE pg
// DLY_VC  | VCORE good, delay before enabling P1V8
// WAIT_18 | P1V8 enabled, waiting for its pg
// DLY_18  | P1V8 good, delay before enabling P3V3
// WAIT_33 | P3V3 enabled, waiting for its pg
// DLY_33  | P3V3 good, delay before enabling P1V1
// WAIT_11 | P1V1 enabled, waiting for its pg
// DLY_11  | P1V1 good, delay before releasing resets
// ON      | all rails up, resets released
// PDN_11  | P1V1 disabled, delay before dropping P3V3
// PDN_33  | P3V3 disabled, delay before dropping P1V8
// PDN_18  | P1V8 disabled, delay before OFF
// FAULT   | latched fault, everything off
module pwr_seq_ctrl #(
   parameter int ON_DLY_MS     = 6,
   parameter int LAST_DLY_MS   = 10,
   parameter int PG_TIMEOUT_MS = 50,
   parameter int OFF_DLY_MS    = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       ms_tick,
   input  logic       pwr_req,
   input  logic       vcore_pg,
   input  logic       p1v8_pg,
   input  logic       p3v3_pg,
   input  logic       p1v1_pg,
   input  logic       fault_clr,
   output logic       p1v8_en,
   output logic       p3v3_en,
   output logic       p1v1_en,
   output logic       rst_release,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_OFF     = 4'd0,
      S_WAIT_VC = 4'd1,
      S_DLY_VC  = 4'd2,
      S_WAIT_18 = 4'd3,
      S_DLY_18  = 4'd4,
      S_WAIT_33 = 4'd5,
      S_DLY_33  = 4'd6,
      S_WAIT_11 = 4'd7,
      S_DLY_11  = 4'd8,
      S_ON      = 4'd9,
      S_PDN_11  = 4'd10,
      S_PDN_33  = 4'd11,
      S_PDN_18  = 4'd12,
      S_FAULT   = 4'd15
   } state_t;

   localparam logic [7:0] ON_N   = 8'(ON_DLY_MS);
   localparam logic [7:0] LAST_N = 8'(LAST_DLY_MS);
   localparam logic [7:0] TO_N   = 8'(PG_TIMEOUT_MS);
   localparam logic [7:0] OFF_N  = 8'(OFF_DLY_MS);

   state_t     cur, nxt;
   logic [3:0] pg_meta, pg_sync;
   logic [7:0] cnt, cnt_inc;
   logic       vc_ok, ok18, ok33, ok11;
   logic       hit_on, hit_last, hit_to, hit_off;
   logic       loss;
   logic [2:0] loss_code;
   logic       n_en18, n_en33, n_en11, n_rst, n_fault;
   logic [2:0] n_code;

   // bit order {p1v1, p3v3, p1v8, vcore}
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pg_meta <= '0;
         pg_sync <= '0;
      end else begin
         pg_meta <= {p1v1_pg, p3v3_pg, p1v8_pg, vcore_pg};
         pg_sync <= pg_meta;
      end
   end

   assign vc_ok = pg_sync[0];
   assign ok18  = pg_sync[1];
   assign ok33  = pg_sync[2];
   assign ok11  = pg_sync[3];

   assign cnt_inc  = (ms_tick && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
   assign hit_on   = (cnt_inc == ON_N);
   assign hit_last = (cnt_inc == LAST_N);
   assign hit_to   = (cnt_inc == TO_N);
   assign hit_off  = (cnt_inc == OFF_N);

   // Only rails whose pg has already been accepted are monitored.
   always_comb begin
      loss      = 1'b0;
      loss_code = 3'd0;
      if (cur >= S_DLY_VC && cur <= S_ON) begin
         if (!vc_ok) begin
            loss = 1'b1; loss_code = 3'd1;
         end else if (cur >= S_DLY_18 && !ok18) begin
            loss = 1'b1; loss_code = 3'd5;
         end else if (cur >= S_DLY_33 && !ok33) begin
            loss = 1'b1; loss_code = 3'd6;
         end else if (cur >= S_DLY_11 && !ok11) begin
            loss = 1'b1; loss_code = 3'd7;
         end
      end
   end

   always_comb begin
      nxt     = cur;
      n_en18  = p1v8_en;
      n_en33  = p3v3_en;
      n_en11  = p1v1_en;
      n_rst   = rst_release;
      n_fault = fault;
      n_code  = fault_code;
      case (cur)
         S_OFF:    if (pwr_req) nxt = S_WAIT_VC;
         S_FAULT: begin
            if (fault_clr && !pwr_req) begin
               nxt     = S_OFF;
               n_fault = 1'b0;
               n_code  = 3'd0;
            end
         end
         S_PDN_11: if (hit_off) begin nxt = S_PDN_33; n_en33 = 1'b0; end
         S_PDN_33: if (hit_off) begin nxt = S_PDN_18; n_en18 = 1'b0; end
         S_PDN_18: if (hit_off) nxt = S_OFF;
         default: begin
            if (loss) begin
               nxt = S_FAULT; n_code = loss_code;
            end else if (!pwr_req) begin
               n_rst = 1'b0;
               if (p1v1_en)      begin nxt = S_PDN_11; n_en11 = 1'b0; end
               else if (p3v3_en) begin nxt = S_PDN_33; n_en33 = 1'b0; end
               else if (p1v8_en) begin nxt = S_PDN_18; n_en18 = 1'b0; end
               else                    nxt = S_OFF;
            end else begin
               case (cur)
                  S_WAIT_VC: if (vc_ok) nxt = S_DLY_VC;
                             else if (hit_to) begin nxt = S_FAULT; n_code = 3'd1; end
                  S_DLY_VC:  if (hit_on) begin nxt = S_WAIT_18; n_en18 = 1'b1; end
                  S_WAIT_18: if (ok18) nxt = S_DLY_18;
                             else if (hit_to) begin nxt = S_FAULT; n_code = 3'd2; end
                  S_DLY_18:  if (hit_on) begin nxt = S_WAIT_33; n_en33 = 1'b1; end
                  S_WAIT_33: if (ok33) nxt = S_DLY_33;
                             else if (hit_to) begin nxt = S_FAULT; n_code = 3'd3; end
                  S_DLY_33:  if (hit_on) begin nxt = S_WAIT_11; n_en11 = 1'b1; end
                  S_WAIT_11: if (ok11) nxt = S_DLY_11;
                             else if (hit_to) begin nxt = S_FAULT; n_code = 3'd4; end
                  S_DLY_11:  if (hit_last) begin nxt = S_ON; n_rst = 1'b1; end
                  default:   nxt = cur;
               endcase
            end
            if (nxt == S_FAULT) begin
               n_en18  = 1'b0;
               n_en33  = 1'b0;
               n_en11  = 1'b0;
               n_rst   = 1'b0;
               n_fault = 1'b1;
            end
         end
      endcase
   end

   // A tick on the transition edge counts toward the new state.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cur         <= S_OFF;
         cnt         <= 8'd0;
         p1v8_en     <= 1'b0;
         p3v3_en     <= 1'b0;
         p1v1_en     <= 1'b0;
         rst_release <= 1'b0;
         fault       <= 1'b0;
         fault_code  <= 3'd0;
      end else begin
         cur         <= nxt;
         cnt         <= (nxt != cur) ? {7'd0, ms_tick} : cnt_inc;
         p1v8_en     <= n_en18;
         p3v3_en     <= n_en33;
         p1v1_en     <= n_en11;
         rst_release <= n_rst;
         fault       <= n_fault;
         fault_code  <= n_code;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: bring-up timing, PG timeout, rail loss,
// power-down ordering, partial power-down and mid-sequence reset.
module tb_pwr_seq_ctrl;
   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       ms_tick = 1'b0;
   logic       pwr_req = 1'b0;
   logic       vcore_pg = 1'b0, p1v8_pg = 1'b0, p3v3_pg = 1'b0, p1v1_pg = 1'b0;
   logic       fault_clr = 1'b0;
   logic       p1v8_en, p3v3_en, p1v1_en, rst_release, fault;
   logic [2:0] fault_code;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;
   int tick_cnt = 0;
   int tick_div = 0;

   pwr_seq_ctrl #(
      .ON_DLY_MS(6), .LAST_DLY_MS(10), .PG_TIMEOUT_MS(20), .OFF_DLY_MS(2)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .ms_tick(ms_tick), .pwr_req(pwr_req),
      .vcore_pg(vcore_pg), .p1v8_pg(p1v8_pg), .p3v3_pg(p3v3_pg), .p1v1_pg(p1v1_pg),
      .fault_clr(fault_clr), .p1v8_en(p1v8_en), .p3v3_en(p3v3_en), .p1v1_en(p1v1_en),
      .rst_release(rst_release), .fault(fault), .fault_code(fault_code), .state(state)
   );

   always #10 sys_clk = ~sys_clk;

   // one-cycle ms_tick every 10 clocks
   initial forever begin
      @(posedge sys_clk);
      #1;
      tick_div = (tick_div == 9) ? 0 : tick_div + 1;
      ms_tick  = (tick_div == 9);
   end

   always @(posedge sys_clk) if (ms_tick) tick_cnt <= tick_cnt + 1;

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_state(input logic [3:0] tgt, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge sys_clk);
         if (state == tgt) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ticks(input int n);
      int s;
      s = tick_cnt;
      for (int i = 0; i < n * 10 + 20; i++) begin
         @(negedge sys_clk);
         if (tick_cnt - s >= n) break;
      end
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      pwr_req = 1'b0; fault_clr = 1'b0;
      {p1v1_pg, p3v3_pg, p1v8_pg, vcore_pg} = 4'b0000;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
   endtask

   // pgs = {p1v1, p3v3, p1v8, vcore}
   task automatic bring_up(input logic [3:0] pgs, input logic [3:0] stop_at);
      bit ok;
      pwr_req = 1'b1;
      {p1v1_pg, p3v3_pg, p1v8_pg, vcore_pg} = pgs;
      wait_state(stop_at, 1000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bring_up: state %0d never reached, at %0d", stop_at, state);
      end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; pwr_req = 1'b1; vcore_pg = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++;
      if (state !== 4'd0) begin
         errors++; $display("FAIL reset_state: got %0d want 0", state);
      end
      checks++;
      if ({p1v8_en, p3v3_en, p1v1_en, rst_release, fault} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {p1v8_en, p3v3_en, p1v1_en, rst_release, fault});
      end
      checks++;
      if (fault_code !== 3'd0) begin
         errors++; $display("FAIL reset_code: got %0d want 0", fault_code);
      end
      sys_rst = 1'b0; pwr_req = 1'b0; vcore_pg = 1'b0;
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_power_up();
      logic [3:0] tgt[4]  = '{4'd3, 4'd5, 4'd7, 4'd9};
      logic [3:0] outs[4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
      int lo[4] = '{5, 5, 5, 9};
      int hi[4] = '{7, 7, 7, 11};
      int t0, dt;
      bit ok;
      pwr_req = 1'b1;
      wait_state(4'd1, 20, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL up_wait_vc: got state %0d want 1", state);
      end
      for (int i = 0; i < 4; i++) begin
         wait_ticks(3);
         t0 = tick_cnt;
         case (i)
            0: vcore_pg = 1'b1;
            1: p1v8_pg  = 1'b1;
            2: p3v3_pg  = 1'b1;
            default: p1v1_pg = 1'b1;
         endcase
         wait_state(tgt[i], 300, ok);
         dt = tick_cnt - t0;
         checks++;
         if (!ok || dt < lo[i] || dt > hi[i]) begin
            errors++;
            $display("FAIL up_delay_%0d: reached=%0d ticks=%0d want %0d..%0d", i, ok, dt, lo[i], hi[i]);
         end
         checks++;
         if ({p1v8_en, p3v3_en, p1v1_en, rst_release} !== outs[i]) begin
            errors++;
            $display("FAIL up_order_%0d: got %b want %b", i,
                     {p1v8_en, p3v3_en, p1v1_en, rst_release}, outs[i]);
         end
      end
      repeat (5) @(negedge sys_clk);
      checks++;
      if (state !== 4'd9 || fault !== 1'b0) begin
         errors++; $display("FAIL up_final: state=%0d fault=%b want 9/0", state, fault);
      end
   endtask

   task automatic test_timeout();
      int t0, dt;
      bit ok;
      do_reset();
      bring_up(4'b0011, 4'd5);
      t0 = tick_cnt;
      wait_state(4'd15, 400, ok);
      dt = tick_cnt - t0;
      checks++;
      if (!ok || dt < 19 || dt > 20) begin
         errors++; $display("FAIL timeout_delay: reached=%0d ticks=%0d want 19..20", ok, dt);
      end
      checks++;
      if (fault_code !== 3'd3 || fault !== 1'b1) begin
         errors++; $display("FAIL timeout_code: code=%0d fault=%b want 3/1", fault_code, fault);
      end
      checks++;
      if ({p1v8_en, p3v3_en, p1v1_en, rst_release} !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_outputs: got %b want 0000", {p1v8_en, p3v3_en, p1v1_en, rst_release});
      end
      fault_clr = 1'b1;
      repeat (3) @(negedge sys_clk);
      checks++;
      if (state !== 4'd15 || fault !== 1'b1) begin
         errors++; $display("FAIL clr_ignored: state=%0d fault=%b want 15/1", state, fault);
      end
      pwr_req = 1'b0;
      @(negedge sys_clk);
      fault_clr = 1'b0;
      checks++;
      if (state !== 4'd0 || fault !== 1'b0 || fault_code !== 3'd0) begin
         errors++;
         $display("FAIL clr_exit: state=%0d fault=%b code=%0d want 0/0/0", state, fault, fault_code);
      end
   endtask

   task automatic test_rail_loss();
      do_reset();
      bring_up(4'b1111, 4'd9);
      p1v8_pg = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++;
      if (state !== 4'd9) begin
         errors++; $display("FAIL loss_latency: state=%0d want 9 after 2 cycles", state);
      end
      @(negedge sys_clk);
      checks++;
      if (state !== 4'd15 || fault_code !== 3'd5) begin
         errors++; $display("FAIL loss_1v8: state=%0d code=%0d want 15/5", state, fault_code);
      end
      checks++;
      if ({p1v8_en, p3v3_en, p1v1_en, rst_release} !== 4'b0000) begin
         errors++;
         $display("FAIL loss_outputs: got %b want 0000", {p1v8_en, p3v3_en, p1v1_en, rst_release});
      end
      pwr_req = 1'b0; fault_clr = 1'b1;
      @(negedge sys_clk);
      fault_clr = 1'b0;
      bring_up(4'b1111, 4'd9);
      vcore_pg = 1'b0; p1v1_pg = 1'b0;
      repeat (3) @(negedge sys_clk);
      checks++;
      if (state !== 4'd15 || fault_code !== 3'd1) begin
         errors++; $display("FAIL loss_priority: state=%0d code=%0d want 15/1", state, fault_code);
      end
   endtask

   task automatic test_power_down();
      int t0, dt;
      bit ok;
      do_reset();
      bring_up(4'b1111, 4'd9);
      pwr_req = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (state !== 4'd10 || {p1v8_en, p3v3_en, p1v1_en, rst_release} !== 4'b1100) begin
         errors++;
         $display("FAIL pdn_entry: state=%0d outs=%b want 10/1100", state,
                  {p1v8_en, p3v3_en, p1v1_en, rst_release});
      end
      pwr_req = 1'b1;
      t0 = tick_cnt;
      wait_state(4'd11, 100, ok);
      dt = tick_cnt - t0;
      checks++;
      if (!ok || dt < 1 || dt > 2 || {p1v8_en, p3v3_en} !== 2'b10) begin
         errors++;
         $display("FAIL pdn_33: reached=%0d ticks=%0d en=%b want 1..2/10", ok, dt, {p1v8_en, p3v3_en});
      end
      t0 = tick_cnt;
      wait_state(4'd12, 100, ok);
      dt = tick_cnt - t0;
      checks++;
      if (!ok || dt < 1 || dt > 2 || p1v8_en !== 1'b0) begin
         errors++; $display("FAIL pdn_18: reached=%0d ticks=%0d en=%b want 1..2/0", ok, dt, p1v8_en);
      end
      wait_state(4'd0, 100, ok);
      pwr_req = 1'b0;
      checks++;
      if (!ok || fault !== 1'b0) begin
         errors++; $display("FAIL pdn_off: reached=%0d fault=%b want 1/0", ok, fault);
      end
   endtask

   task automatic test_partial();
      bit ok;
      do_reset();
      bring_up(4'b0011, 4'd5);
      pwr_req = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (state !== 4'd11 || {p1v8_en, p3v3_en} !== 2'b10) begin
         errors++;
         $display("FAIL partial_entry: state=%0d en=%b want 11/10", state, {p1v8_en, p3v3_en});
      end
      wait_state(4'd12, 100, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL partial_18: state=%0d want 12", state);
      end
      wait_state(4'd0, 100, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL partial_off: state=%0d want 0", state);
      end
      do_reset();
      bring_up(4'b0001, 4'd2);
      pwr_req = 1'b0;
      @(negedge sys_clk);
      checks++;
      if (state !== 4'd0 || p1v8_en !== 1'b0) begin
         errors++; $display("FAIL partial_dly_vc: state=%0d en=%b want 0/0", state, p1v8_en);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bring_up(4'b0011, 4'd4);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (state !== 4'd0 || {p1v8_en, p3v3_en, p1v1_en, rst_release, fault} !== 5'b00000
          || fault_code !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid: state=%0d outs=%b code=%0d want 0/00000/0", state,
                  {p1v8_en, p3v3_en, p1v1_en, rst_release, fault}, fault_code);
      end
      sys_rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_timeout();
      test_rail_loss();
      test_power_down();
      test_partial();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Board power-sequencing controller for the BMU CPLD. It replaces the free-running chain of per-rail delay timers with a single state machine. The machine brings up P1V8, P3V3 and P1V1 in order after VCORE power-good, then releases the BMC PCIe/PHY resets. It adds power-good timeouts, rail-loss fault latching and ordered reverse power-down. It sits in the top level between the 1 ms tick timer, the regulator enable/PWRGD pins and the reset outputs; state and fault code are exported for the I2C debug port.

## Interface
- ON_DLY_MS, 6: ms held after a rail's PG before enabling the next rail.
- LAST_DLY_MS, 10: ms held after P1V1 PG before releasing resets.
- PG_TIMEOUT_MS, 50: max ms to wait for a PG after its enable (or after pwr_req for VCORE).
- OFF_DLY_MS, 2: ms between successive rail disables during power-down.
- All parameters 1..255; 8-bit counter.

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst  in  1  synchronous, active-high reset.
- ms_tick  in  1  one-cycle pulse once per ms.
- pwr_req  in  1  power request (VCORE_EN); level.
- vcore_pg, p1v8_pg, p3v3_pg, p1v1_pg  in  1 each  async power-good inputs.
- fault_clr  in  1  clears a latched fault; honoured only while pwr_req=0.
- p1v8_en, p3v3_en, p1v1_en  out  1 each  regulator enables, registered.
- rst_release  out  1  1 = deassert BMC PCIe/PHY resets, registered.
- fault  out  1  latched fault flag.
- fault_code  out  3  0 none; 1 VCORE timeout/lost; 2/3/4 P1V8/P3V3/P1V1 PG timeout; 5/6/7 P1V8/P3V3/P1V1 PG lost.
- state  out  4  current state encoding.

## Operation
- All PG inputs pass through 2-flop synchronizers; "pg" below means the synchronized value.
- States and encodings:
  - OFF=0, WAIT_VC=1, DLY_VC=2, WAIT_18=3, DLY_18=4, WAIT_33=5, DLY_33=6, WAIT_11=7, DLY_11=8.
  - ON=9, PDN_11=10, PDN_33=11, PDN_18=12, FAULT=15.
- OFF: all outputs low. pwr_req=1 -> WAIT_VC.
- WAIT_x waits for that rail's pg:
  - pg=1 -> DLY_x.
  - PG_TIMEOUT_MS ticks counted without pg -> FAULT with code 1/2/3/4.
- Delay states:
  - DLY_VC sets p1v8_en and goes to WAIT_18 after ON_DLY_MS ticks.
  - DLY_18 sets p3v3_en and goes to WAIT_33 after ON_DLY_MS ticks.
  - DLY_33 sets p1v1_en and goes to WAIT_11 after ON_DLY_MS ticks.
  - DLY_11 sets rst_release and goes to ON after LAST_DLY_MS ticks.
- Rail monitoring, all states from DLY_VC through ON:
  - Any previously confirmed rail's pg dropping -> FAULT.
  - Priority vcore > 1v8 > 3v3 > 1v1; codes 1/5/6/7.
- pwr_req=0 in any up-sequence or ON state enters power-down at the highest enabled rail:
  - rst_release cleared on the same transition.
  - p1v1_en=1 -> PDN_11; else p3v3_en=1 -> PDN_33; else p1v8_en=1 -> PDN_18; else -> OFF.
- PDN_x: that rail's enable is cleared on entry. After OFF_DLY_MS ticks: PDN_11 -> PDN_33 -> PDN_18 -> OFF.
- During PDN, PG loss is not a fault and pwr_req=1 is ignored; the sequence always completes to OFF.
- FAULT:
  - All enables and rst_release forced low on entry; fault=1 and fault_code latched.
  - Exit to OFF only when fault_clr=1 and pwr_req=0 in the same cycle; fault and fault_code clear on that exit.
- Simultaneous events: fault detection beats pwr_req=0 beats a delay/timeout expiring. A timeout and a PG arriving in the same cycle -> PG wins.

## Timing
- Reset (sys_rst=1 at a clock edge): state=OFF; all enables, rst_release, fault = 0; fault_code=0; counter=0. Reset overrides everything, including mid-sequence and FAULT.
- Tick counter clears on every state change. It increments on ms_tick. The transition is registered on the edge where the count reaches N, so the actual delay is between N-1 ms and N ms.
- Latency:
  - Outputs change on the same edge as the state transition that sets them.
  - PG input to state change: 3 cycles (2 synchronizer stages + 1 register).
- ms_tick coinciding with a state change counts toward the new state.

## Test plan
- Bench setup for all scenarios: ms_tick every 10 cycles; ON_DLY_MS=6, LAST_DLY_MS=10, PG_TIMEOUT_MS=20, OFF_DLY_MS=2.
- Normal up: pwr_req=1, each PG driven 3 ticks after its enable. Required: p1v8_en, p3v3_en, p1v1_en and rst_release rise in that order, each 6/6/6/10 ticks (±1) after the preceding PG; state ends at 9; fault=0.
- Timeout: leave p3v3_pg=0. Required: 20 ticks after p3v3_en, state=15, fault_code=3, all enables and rst_release low. fault_clr with pwr_req=1 is ignored; fault_clr with pwr_req=0 returns to state 0.
- Rail loss in ON: drop p1v8_pg. Required: FAULT with code 5 within 3 cycles. Dropping vcore_pg and p1v1_pg in the same cycle gives code 1.
- Power-down from ON: pwr_req=0. Required: rst_release and p1v1_en low at once, p3v3_en low 2 ticks later, p1v8_en low 2 ticks after that, then state 0. pwr_req=1 mid-sequence has no effect.
- Partial power-down: pwr_req=0 during WAIT_33. Required: entry to PDN_33, then PDN_18, then OFF. pwr_req=0 during DLY_VC goes directly to OFF.
- Reset mid-sequence: sys_rst=1 in DLY_18. Required: all outputs 0 and state 0 on the next edge.
